dmem_responder: RTL and testbench

- Data-memory target for the pipeline's MEM stage; answers the load/store requests that the pipeline issues through its MemRead/MemWrite/address/write-data lines.
- Adds configurable wait states and a STALL back-pressure output, so that the pipeline holds its EX/MEM register until the access completes.
- Holds a word-addressed synchronous RAM with byte-enable writes, and flags misaligned or conflicting requests.

---
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory target for the pipeline MEM stage. It serves load/store
// requests from a word-addressed synchronous RAM with byte-enable writes.
// Every access is held off by LATENCY wait cycles, and STALL tells the
// pipeline to keep its EX/MEM register while an access is in progress.
// A misaligned address, or a request with both MemRead and MemWrite set,
// is answered with a READY + ADDR_ERR pulse and has no other effect.
//
// Ports:
//   CLK        in   1   system clock, rising edge
//   RST_N      in   1   asynchronous active-low reset
//   MemRead    in   1   load request (held stable while STALL=1)
//   MemWrite   in   1   store request (held stable while STALL=1)
//   ADDR       in  32   byte address; only bits [AW+1:2] select the word
//   WRITE_DATA in  32   store data
//   BYTE_EN    in   4   store byte lanes, bit i enables byte i
//   READ_DATA  out 32   registered load result, held until the next load
//   READY      out  1   one-cycle completion pulse
//   STALL      out  1   combinational hold request to the pipeline
//   ADDR_ERR   out  1   one-cycle error pulse, coincident with READY
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ADDR,
    input  logic [31:0] WRITE_DATA,
    input  logic [3:0]  BYTE_EN,
    output logic [31:0] READ_DATA,
    output logic        READY,
    output logic        STALL,
    output logic        ADDR_ERR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic          req;
    logic          bad;
    logic          do_acc;
    logic          mem_we;
    logic [AW-1:0] index;

    // Upper address bits are deliberately ignored (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, ADDR[31:AW+2]};

    assign req   = MemRead | MemWrite;
    assign bad   = (ADDR[1:0] != 2'b00) | (MemRead & MemWrite);
    assign index = ADDR[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        do_acc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (bad) begin
                        state_d = S_ERR;
                    end else if (LATENCY == 0) begin
                        do_acc  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = 4'(LATENCY - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A request that vanishes mid-wait is abandoned silently.
                if (!req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    do_acc  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (do_acc && MemRead) begin
                rdata_q <= mem[index];
            end
        end
    end

    // The RAM has no reset; the write is qualified with RST_N so that a
    // zero-latency request seen while reset is held cannot write.
    assign mem_we = do_acc & MemWrite & RST_N;

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (BYTE_EN[i]) begin
                    mem[index][8*i +: 8] <= WRITE_DATA[8*i +: 8];
                end
            end
        end
    end

    assign READ_DATA = rdata_q;
    assign READY     = (state_q == S_DONE) | (state_q == S_ERR);
    assign ADDR_ERR  = (state_q == S_ERR);
    assign STALL     = req & ((state_q == S_IDLE) | (state_q == S_WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with LATENCY=2 and one
// with LATENCY=0 share the stimulus; a select picks which outputs the
// transfer task observes.
module tb_dmem_responder;

    logic        CLK;
    logic        RST_N;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ADDR;
    logic [31:0] WRITE_DATA;
    logic [3:0]  BYTE_EN;

    logic [31:0] rd2, rd0;
    logic        rdy2, rdy0, stl2, stl0, err2, err0;

    logic        sel0;
    logic [31:0] r_data;
    logic        r_ready, r_stall, r_err;

    int unsigned n_checks;
    int unsigned n_pass;

    int unsigned lat, stalls;
    logic        e_flag, stall_done, ready_after;

    dmem_responder #(.DEPTH_WORDS(256), .AW(8), .LATENCY(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .MemRead(MemRead), .MemWrite(MemWrite),
        .ADDR(ADDR), .WRITE_DATA(WRITE_DATA), .BYTE_EN(BYTE_EN),
        .READ_DATA(rd2), .READY(rdy2), .STALL(stl2), .ADDR_ERR(err2)
    );

    dmem_responder #(.DEPTH_WORDS(256), .AW(8), .LATENCY(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .MemRead(MemRead), .MemWrite(MemWrite),
        .ADDR(ADDR), .WRITE_DATA(WRITE_DATA), .BYTE_EN(BYTE_EN),
        .READ_DATA(rd0), .READY(rdy0), .STALL(stl0), .ADDR_ERR(err0)
    );

    assign r_data  = sel0 ? rd0  : rd2;
    assign r_ready = sel0 ? rdy0 : rdy2;
    assign r_stall = sel0 ? stl0 : stl2;
    assign r_err   = sel0 ? err0 : err2;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drives one request (caller is at posedge+1 with the DUT idle), counts
    // cycles until READY and STALL cycles, then drops the request.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int unsigned cyc, output int unsigned nstall,
                        output logic err, output logic stall_at_done,
                        output logic ready_next);
        MemRead = rd; MemWrite = wr; ADDR = a; WRITE_DATA = wd; BYTE_EN = be;
        cyc = 0; nstall = 0;
        #1;
        while (!r_ready && cyc < 20) begin
            if (r_stall) nstall++;
            @(posedge CLK); #1;
            cyc++;
        end
        err = r_err;
        stall_at_done = r_stall;
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge CLK); #1;
        ready_next = r_ready;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; sel0 = 1'b0;
        RST_N = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        ADDR = '0; WRITE_DATA = '0; BYTE_EN = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_rdata", r_data, 32'h0);
        check("rst_ready", {31'b0, r_ready}, 32'h0);
        check("rst_err",   {31'b0, r_err},   32'h0);
        check("rst_stall", {31'b0, r_stall}, 32'h0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Store 0xDEADBEEF at 0x10
        xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, stalls, e_flag, stall_done, ready_after);
        check("st_lat",        lat, 3);
        check("st_stalls",     stalls, 3);
        check("st_stall_done", {31'b0, stall_done}, 32'h0);
        check("st_err",        {31'b0, e_flag}, 32'h0);
        check("st_ready_1cyc", {31'b0, ready_after}, 32'h0);
        check("st_rdata_keep", r_data, 32'h0);

        xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, stalls, e_flag, stall_done, ready_after);
        check("ld_lat",   lat, 3);
        check("ld_data",  r_data, 32'hDEADBEEF);

        // Byte merge, lanes 0 and 2
        xfer(1'b0, 1'b1, 32'h10, 32'h11223344, 4'h5, lat, stalls, e_flag, stall_done, ready_after);
        check("st_keep_rdata", r_data, 32'hDEADBEEF);
        xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, stalls, e_flag, stall_done, ready_after);
        check("merge_data", r_data, 32'hDE22BE44);

        // BYTE_EN=0 still completes and changes nothing
        xfer(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, lat, stalls, e_flag, stall_done, ready_after);
        check("be0_lat", lat, 3);
        xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, stalls, e_flag, stall_done, ready_after);
        check("be0_data", r_data, 32'hDE22BE44);

        // Misaligned load
        xfer(1'b1, 1'b0, 32'h12, 32'h0, 4'h0, lat, stalls, e_flag, stall_done, ready_after);
        check("mis_lat",    lat, 1);
        check("mis_stalls", stalls, 1);
        check("mis_err",    {31'b0, e_flag}, 32'h1);
        check("mis_rdata",  r_data, 32'hDE22BE44);

        // Read+write conflict must not write 0x20
        xfer(1'b0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, lat, stalls, e_flag, stall_done, ready_after);
        xfer(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, lat, stalls, e_flag, stall_done, ready_after);
        check("rw_lat", lat, 1);
        check("rw_err", {31'b0, e_flag}, 32'h1);
        xfer(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, stalls, e_flag, stall_done, ready_after);
        check("rw_nowrite", r_data, 32'h0BADF00D);
        check("good_noerr", {31'b0, e_flag}, 32'h0);

        // Wrap: 0x400 aliases word 0
        xfer(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, lat, stalls, e_flag, stall_done, ready_after);
        xfer(1'b1, 1'b0, 32'h000, 32'h0, 4'h0, lat, stalls, e_flag, stall_done, ready_after);
        check("wrap_data", r_data, 32'hCAFEF00D);

        // Reset during the WAIT of a store to 0x10
        MemWrite = 1'b1; ADDR = 32'h10; WRITE_DATA = 32'h55555555; BYTE_EN = 4'hF;
        @(posedge CLK); #1;
        check("rst_mid_stall", {31'b0, r_stall}, 32'h1);
        RST_N = 1'b0;
        #1;
        check("rst_mid_rdata", r_data, 32'h0);
        check("rst_mid_ready", {31'b0, r_ready}, 32'h0);
        repeat (3) @(posedge CLK);
        #1;
        MemWrite = 1'b0;
        #1;
        check("rst_mid_stall0", {31'b0, r_stall}, 32'h0);
        RST_N = 1'b1;
        @(posedge CLK); #1;
        xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, stalls, e_flag, stall_done, ready_after);
        check("rst_mid_idle_lat", lat, 3);
        check("rst_mid_nowrite",  r_data, 32'hDE22BE44);

        // Dropping MemRead in WAIT abandons the load
        RST_N = 1'b0; #1; RST_N = 1'b1;
        @(posedge CLK); #1;
        MemRead = 1'b1; ADDR = 32'h10;
        @(posedge CLK); #1;
        MemRead = 1'b0;
        begin
            int unsigned seen;
            seen = 0;
            for (int k = 0; k < 5; k++) begin
                @(posedge CLK); #1;
                if (r_ready) seen++;
            end
            check("drop_no_ready", seen, 0);
        end
        check("drop_rdata", r_data, 32'h0);
        xfer(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, stalls, e_flag, stall_done, ready_after);
        check("drop_idle_lat", lat, 3);
        check("drop_then_ld", r_data, 32'hDE22BE44);

        // LATENCY=0 instance
        sel0 = 1'b1;
        xfer(1'b0, 1'b1, 32'h8, 32'h12345678, 4'hF, lat, stalls, e_flag, stall_done, ready_after);
        check("l0_st_lat",    lat, 1);
        check("l0_st_stalls", stalls, 1);
        check("l0_stall_done", {31'b0, stall_done}, 32'h0);
        xfer(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, lat, stalls, e_flag, stall_done, ready_after);
        check("l0_ld_lat",  lat, 1);
        check("l0_ld_data", r_data, 32'h12345678);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
